// File: rtl/sp_emu_pkg.sv
// Shared constants and types for the SuperMario chip emulator.
package sp_emu_pkg;

   localparam logic [6:0] ADDR_ID   = 7'h00;
   localparam logic [6:0] ADDR_CTRL = 7'h01;
   localparam logic [6:0] ADDR_SEED = 7'h02;
   localparam logic [6:0] ADDR_FCNT = 7'h03;

   localparam int CTRL_RUN = 0;
   localparam int CTRL_PAT = 1;

   // Counts 0..16; 16 means "past the last data bit" and saturates there.
   localparam int SPI_CNT_W = 5;
   localparam logic [SPI_CNT_W-1:0] SPI_BIT_RW        = 5'd0;
   localparam logic [SPI_CNT_W-1:0] SPI_BIT_ADDR_LAST = 5'd7;
   localparam logic [SPI_CNT_W-1:0] SPI_BIT_DATA_LAST = 5'd15;
   localparam logic [SPI_CNT_W-1:0] SPI_BIT_DONE      = 5'd16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_GAP    = 2'd2
   } frame_state_e;

endpackage

// File: rtl/sp_emu_spi.sv
// SPI responder and register file: decodes R/W + 7-bit address frames,
// holds CTRL and SEED, reads back ID and the frame counter.
module sp_emu_spi
   import sp_emu_pkg::*;
#(
   parameter logic [7:0] CHIP_ID = 8'h5A
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       spi_cs_n,
   input  logic       spi_mosi,
   input  logic [7:0] fcnt_i,
   output logic       spi_miso,
   output logic [1:0] ctrl_o,
   output logic [7:0] seed_o
);

   logic [SPI_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic [6:0]           shift_q, shift_d;
   logic [6:0]           addr_q, addr_d;
   logic                 rd_q, rd_d;
   logic [7:0]           rd_shift_q, rd_shift_d;
   logic                 miso_q, miso_d;
   logic [1:0]           ctrl_q, ctrl_d;
   logic [7:0]           seed_q, seed_d;

   logic [6:0]           addr_now;
   logic [7:0]           wdata;
   logic [7:0]           rdata;

   assign addr_now = {shift_q[5:0], spi_mosi};
   assign wdata    = {shift_q[6:0], spi_mosi};

   // Read mux for the address being completed this cycle (snapshot source).
   always_comb begin
      rdata = 8'h00;
      case (addr_now)
         ADDR_ID:   rdata = CHIP_ID;
         ADDR_CTRL: rdata = {6'b0, ctrl_q};
         ADDR_SEED: rdata = seed_q;
         ADDR_FCNT: rdata = fcnt_i;
         default:   rdata = 8'h00;
      endcase
   end

   // Bit sequencing, read shift-out and register writes.
   always_comb begin
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      addr_d     = addr_q;
      rd_d       = rd_q;
      rd_shift_d = rd_shift_q;
      miso_d     = 1'b0;
      ctrl_d     = ctrl_q;
      seed_d     = seed_q;
      if (spi_cs_n) begin
         bit_cnt_d = '0;
      end else begin
         shift_d = {shift_q[5:0], spi_mosi};
         if (bit_cnt_q != SPI_BIT_DONE) begin
            bit_cnt_d = bit_cnt_q + SPI_CNT_W'(1);
         end
         if (bit_cnt_q == SPI_BIT_RW) begin
            rd_d = spi_mosi;
         end
         if (bit_cnt_q == SPI_BIT_ADDR_LAST) begin
            // miso is registered, so the MSB leaves now to be valid during bit 8.
            addr_d     = addr_now;
            rd_shift_d = {rdata[6:0], 1'b0};
            miso_d     = rd_q & rdata[7];
         end else if ((bit_cnt_q > SPI_BIT_ADDR_LAST) && (bit_cnt_q < SPI_BIT_DATA_LAST)) begin
            rd_shift_d = {rd_shift_q[6:0], 1'b0};
            miso_d     = rd_q & rd_shift_q[7];
         end else if ((bit_cnt_q == SPI_BIT_DATA_LAST) && !rd_q) begin
            case (addr_q)
               ADDR_CTRL: ctrl_d = wdata[1:0];
               ADDR_SEED: seed_d = wdata;
               default:   begin end
            endcase
         end
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         addr_q     <= '0;
         rd_q       <= 1'b0;
         rd_shift_q <= '0;
         miso_q     <= 1'b0;
         ctrl_q     <= '0;
         seed_q     <= '0;
      end else begin
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         addr_q     <= addr_d;
         rd_q       <= rd_d;
         rd_shift_q <= rd_shift_d;
         miso_q     <= miso_d;
         ctrl_q     <= ctrl_d;
         seed_q     <= seed_d;
      end
   end

   assign spi_miso = miso_q;
   assign ctrl_o   = ctrl_q;
   assign seed_o   = seed_q;

endmodule

// File: rtl/sp_chip_emu.sv
// Behavioural model of the SuperMario chip side of the readout link:
// frame FSM, ramp/echo pattern generator and the SPI register block.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ST_IDLE   | no output; waits for CTRL.RUN, latches PAT on exit
//   ST_STREAM | one pixel per cycle, pix_cnt 0..PIXELS-1
//   ST_GAP    | GAP quiet cycles (down-counter), then restart or idle
module sp_chip_emu
   import sp_emu_pkg::*;
#(
   parameter int         PIXELS  = 1024,
   parameter int         GAP     = 16,
   parameter logic [7:0] CHIP_ID = 8'h5A
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sp_nrst,
   input  logic [7:0] sp_din,
   input  logic       sp_spi_cs,
   input  logic       sp_spi_mosi,
   output logic [7:0] sp_dout,
   output logic       sp_update,
   output logic       sp_eof,
   output logic       sp_spi_miso
);

   localparam int PIX_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;
   localparam int GAP_W = $clog2(GAP + 1);
   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);

   logic             srst;
   logic [1:0]       ctrl;
   logic [7:0]       seed;
   logic             run;

   frame_state_e     state_q, state_d;
   logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
   logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
   logic             pat_q, pat_d;
   logic [7:0]       fcnt_q, fcnt_d;
   logic [7:0]       din_q, din_d;
   logic [7:0]       dout_q, dout_d;
   logic             update_q, update_d;
   logic             eof_q, eof_d;
   logic [7:0]       pixel;

   // The chip reset pin behaves exactly like the block reset.
   assign srst = rst | ~sp_nrst;
   assign run  = ctrl[CTRL_RUN];

   sp_emu_spi #(
      .CHIP_ID (CHIP_ID)
   ) u_spi (
      .clk      (clk),
      .rst      (srst),
      .spi_cs_n (sp_spi_cs),
      .spi_mosi (sp_spi_mosi),
      .fcnt_i   (fcnt_q),
      .spi_miso (sp_spi_miso),
      .ctrl_o   (ctrl),
      .seed_o   (seed)
   );

   // Pixel source: ramp from SEED/FCNT, or DIN delayed one cycle.
   always_comb begin
      pixel = 8'h00;
      if (pat_q) begin
         pixel = din_q;
      end else begin
         pixel = seed + fcnt_q + 8'(pix_cnt_q);
      end
   end

   // Frame sequencing; PAT only changes at a frame start.
   always_comb begin
      state_d   = state_q;
      pix_cnt_d = pix_cnt_q;
      gap_cnt_d = gap_cnt_q;
      pat_d     = pat_q;
      fcnt_d    = fcnt_q;
      din_d     = sp_din;
      dout_d    = dout_q;
      update_d  = 1'b0;
      eof_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run) begin
               state_d   = ST_STREAM;
               pix_cnt_d = '0;
               pat_d     = ctrl[CTRL_PAT];
            end
         end
         ST_STREAM: begin
            update_d = 1'b1;
            dout_d   = pixel;
            if (pix_cnt_q == PIX_LAST) begin
               eof_d     = 1'b1;
               fcnt_d    = fcnt_q + 8'd1;
               gap_cnt_d = GAP_LOAD;
               state_d   = ST_GAP;
            end else begin
               pix_cnt_d = pix_cnt_q + PIX_W'(1);
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == '0) begin
               if (run) begin
                  state_d   = ST_STREAM;
                  pix_cnt_d = '0;
                  pat_d     = ctrl[CTRL_PAT];
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (srst) begin
         state_q   <= ST_IDLE;
         pix_cnt_q <= '0;
         gap_cnt_q <= '0;
         pat_q     <= 1'b0;
         fcnt_q    <= '0;
         din_q     <= '0;
         dout_q    <= '0;
         update_q  <= 1'b0;
         eof_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pix_cnt_q <= pix_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         pat_q     <= pat_d;
         fcnt_q    <= fcnt_d;
         din_q     <= din_d;
         dout_q    <= dout_d;
         update_q  <= update_d;
         eof_q     <= eof_d;
      end
   end

   assign sp_dout   = dout_q;
   assign sp_update = update_q;
   assign sp_eof    = eof_q;

endmodule

// File: tb/tb_sp_chip_emu.sv
// Directed bench for sp_chip_emu with PIXELS = 8, GAP = 2.
`timescale 1ns/1ps
module tb_sp_chip_emu;

   localparam int PIXELS = 8;
   localparam int GAP    = 2;
   localparam int FRAME  = PIXELS + GAP;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sp_nrst = 1'b1;
   logic [7:0] sp_din = 8'h00;
   logic       sp_spi_cs = 1'b1;
   logic       sp_spi_mosi = 1'b0;
   logic [7:0] sp_dout;
   logic       sp_update;
   logic       sp_eof;
   logic       sp_spi_miso;

   int checks = 0;
   int errors = 0;

   sp_chip_emu #(
      .PIXELS  (PIXELS),
      .GAP     (GAP),
      .CHIP_ID (8'h5A)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sp_nrst     (sp_nrst),
      .sp_din      (sp_din),
      .sp_spi_cs   (sp_spi_cs),
      .sp_spi_mosi (sp_spi_mosi),
      .sp_dout     (sp_dout),
      .sp_update   (sp_update),
      .sp_eof      (sp_eof),
      .sp_spi_miso (sp_spi_miso)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sp_spi_cs = 1'b1;
      sp_spi_mosi = 1'b0;
      repeat (3) step();
      rst = 1'b0;
   endtask

   // Full 16-bit transaction followed by one cs-high cycle.
   task automatic spi_xfer(input logic rw, input logic [6:0] addr,
                           input logic [7:0] wdata, output logic [7:0] rdata);
      logic [15:0] frame;
      frame = {rw, addr, wdata};
      rdata = 8'h00;
      for (int i = 0; i < 16; i++) begin
         sp_spi_cs = 1'b0;
         sp_spi_mosi = frame[15-i];
         if (i >= 8) rdata = {rdata[6:0], sp_spi_miso};
         step();
      end
      sp_spi_cs = 1'b1;
      sp_spi_mosi = 1'b0;
      step();
   endtask

   task automatic test_reset();
      logic [7:0] rd;
      do_reset();
      checks++; if (sp_dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", sp_dout); end
      checks++; if (sp_update !== 1'b0) begin errors++; $display("FAIL reset_update got %b exp 0", sp_update); end
      checks++; if (sp_eof !== 1'b0) begin errors++; $display("FAIL reset_eof got %b exp 0", sp_eof); end
      checks++; if (sp_spi_miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", sp_spi_miso); end
      spi_xfer(1'b1, 7'h00, 8'h00, rd);
      checks++; if (rd !== 8'h5A) begin errors++; $display("FAIL read_id got %h exp 5a", rd); end
      spi_xfer(1'b1, 7'h01, 8'h00, rd);
      checks++; if (rd !== 8'h00) begin errors++; $display("FAIL read_ctrl_rst got %h exp 00", rd); end
      spi_xfer(1'b1, 7'h03, 8'h00, rd);
      checks++; if (rd !== 8'h00) begin errors++; $display("FAIL read_fcnt_rst got %h exp 00", rd); end
   endtask

   // Starts RUN with SEED=0x10, then writes CTRL=0 beginning 'spi_delay' cycles
   // after the FSM enters STREAM; 'nframes' frames are expected in total.
   task automatic run_and_stop(input int spi_delay, input int nframes, input int ncyc,
                               input logic [7:0] exp_fcnt, input string tag);
      logic [7:0] rd, rd2, exp_dout;
      logic       exp_upd;
      int         f, k;
      do_reset();
      spi_xfer(1'b0, 7'h02, 8'h10, rd);
      spi_xfer(1'b0, 7'h01, 8'h01, rd);
      exp_dout = 8'h00;
      fork
         begin
            for (int c = 0; c < ncyc; c++) begin
               f = (c - 1) / FRAME;
               k = (c - 1) % FRAME;
               exp_upd = (c >= 1) && (f < nframes) && (k < PIXELS);
               if (exp_upd) exp_dout = 8'(8'h10 + f + k);
               checks++;
               if (sp_update !== exp_upd) begin
                  errors++; $display("FAIL %s_update c=%0d got %b exp %b", tag, c, sp_update, exp_upd);
               end
               checks++;
               if (sp_dout !== exp_dout) begin
                  errors++; $display("FAIL %s_dout c=%0d got %h exp %h", tag, c, sp_dout, exp_dout);
               end
               checks++;
               if (sp_eof !== (exp_upd && (k == PIXELS - 1))) begin
                  errors++; $display("FAIL %s_eof c=%0d got %b exp %b", tag, c, sp_eof, exp_upd && (k == PIXELS - 1));
               end
               step();
            end
         end
         begin
            repeat (spi_delay) step();
            spi_xfer(1'b0, 7'h01, 8'h00, rd2);
         end
      join
      spi_xfer(1'b1, 7'h03, 8'h00, rd);
      checks++; if (rd !== exp_fcnt) begin errors++; $display("FAIL %s_fcnt got %h exp %h", tag, rd, exp_fcnt); end
   endtask

   task automatic test_ramp();
      // RUN drops during frame 1, so exactly frames 0 and 1 are emitted.
      run_and_stop(0, 2, 26, 8'd2, "ramp");
   endtask

   task automatic test_run_clear();
      // CTRL=0 lands at pixel 3 of frame 2; pixels 4..7 still follow, then idle.
      run_and_stop(7, 3, 42, 8'd3, "runclr");
   endtask

   task automatic test_echo();
      logic [7:0] rd, exp_dout;
      logic       exp_upd;
      int         k;
      do_reset();
      sp_din = 8'h9F;
      spi_xfer(1'b0, 7'h01, 8'h03, rd);
      exp_dout = 8'h00;
      for (int c = 0; c < 20; c++) begin
         sp_din = 8'(8'hA0 + c);
         k = (c - 1) % FRAME;
         exp_upd = (c >= 1) && (k < PIXELS);
         if (exp_upd) exp_dout = (c == 1) ? 8'h9F : 8'(8'hA0 + c - 2);
         checks++;
         if (sp_update !== exp_upd) begin
            errors++; $display("FAIL echo_update c=%0d got %b exp %b", c, sp_update, exp_upd);
         end
         checks++;
         if (sp_dout !== exp_dout) begin
            errors++; $display("FAIL echo_dout c=%0d got %h exp %h", c, sp_dout, exp_dout);
         end
         step();
      end
      do_reset();
   endtask

   task automatic test_spi_abort();
      logic [7:0]  rd;
      logic [15:0] frame;
      do_reset();
      frame = {1'b0, 7'h02, 8'hFF};
      for (int i = 0; i < 12; i++) begin
         sp_spi_cs = 1'b0;
         sp_spi_mosi = frame[15-i];
         step();
      end
      sp_spi_cs = 1'b1;
      sp_spi_mosi = 1'b0;
      step();
      spi_xfer(1'b1, 7'h02, 8'h00, rd);
      checks++; if (rd !== 8'h00) begin errors++; $display("FAIL abort_seed got %h exp 00", rd); end
      spi_xfer(1'b0, 7'h02, 8'h5C, rd);
      spi_xfer(1'b1, 7'h02, 8'h00, rd);
      checks++; if (rd !== 8'h5C) begin errors++; $display("FAIL seed_write got %h exp 5c", rd); end
      spi_xfer(1'b0, 7'h00, 8'h11, rd);
      spi_xfer(1'b1, 7'h00, 8'h00, rd);
      checks++; if (rd !== 8'h5A) begin errors++; $display("FAIL id_ro got %h exp 5a", rd); end
      spi_xfer(1'b0, 7'h01, 8'hFC, rd);
      spi_xfer(1'b1, 7'h01, 8'h00, rd);
      checks++; if (rd !== 8'h00) begin errors++; $display("FAIL ctrl_mask got %h exp 00", rd); end
      spi_xfer(1'b1, 7'h05, 8'h00, rd);
      checks++; if (rd !== 8'h00) begin errors++; $display("FAIL unmapped_read got %h exp 00", rd); end
      checks++; if (sp_update !== 1'b0) begin errors++; $display("FAIL abort_no_run got %b exp 0", sp_update); end
   endtask

   task automatic test_nrst();
      logic [7:0] rd;
      int         bad;
      do_reset();
      spi_xfer(1'b0, 7'h02, 8'h10, rd);
      spi_xfer(1'b0, 7'h01, 8'h01, rd);
      repeat (13) step();
      checks++;
      if ((sp_update !== 1'b1) || (sp_dout !== 8'h13)) begin
         errors++; $display("FAIL nrst_pre got upd=%b dout=%h exp upd=1 dout=13", sp_update, sp_dout);
      end
      sp_nrst = 1'b0;
      step();
      sp_nrst = 1'b1;
      checks++;
      if ({sp_update, sp_eof, sp_dout, sp_spi_miso} !== 11'b0) begin
         errors++; $display("FAIL nrst_outputs got upd=%b eof=%b dout=%h miso=%b exp all 0",
                            sp_update, sp_eof, sp_dout, sp_spi_miso);
      end
      bad = 0;
      for (int c = 0; c < 15; c++) begin
         if (sp_update !== 1'b0 || sp_eof !== 1'b0) bad++;
         step();
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL nrst_idle got %0d active cycles exp 0", bad); end
      spi_xfer(1'b1, 7'h03, 8'h00, rd);
      checks++; if (rd !== 8'h00) begin errors++; $display("FAIL nrst_fcnt got %h exp 00", rd); end
      spi_xfer(1'b1, 7'h01, 8'h00, rd);
      checks++; if (rd !== 8'h00) begin errors++; $display("FAIL nrst_ctrl got %h exp 00", rd); end
   endtask

   initial begin
      test_reset();
      test_ramp();
      test_echo();
      test_run_clear();
      test_spi_abort();
      test_nrst();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sp_chip_emu.md
# sp_chip_emu

Synthesizable behavioural emulator of the SuperMario chip side of the readout link, used for FPGA loopback and bring-up without silicon. It consumes the chip-facing signals the readout drives (chip reset, DIN, SPI CS/MOSI) and produces the signals the readout consumes (DOUT, UPDATE, EOF, SPI MISO). It sits between the LVDS pad wrapper and the readout core, or directly wired to the readout core in simulation. All I/O is true polarity; any LVDS pair inversion belongs to the pad wrapper.

## Interface
- PIXELS, 1024: pixels per frame; must be ≥ 2.
- GAP, 16: idle cycles between frames; must be ≥ 1.
- CHIP_ID, 8'h5A: value of read-only ID register.

- clk  in  1  emulator clock; equals the SP_CLK fed to the chip.
- rst  in  1  synchronous, active-high reset.
- sp_nrst  in  1  chip reset from readout, active-low, sampled synchronously; low acts exactly like rst.
- sp_din  in  8  chip DIN bus; sampled every cycle.
- sp_spi_cs  in  1  SPI chip select, active-low.
- sp_spi_mosi  in  1  SPI data in, sampled on clk while cs low.
- sp_dout  out  8  pixel byte.
- sp_update  out  1  one-cycle strobe per valid sp_dout byte.
- sp_eof  out  1  high with the update of the last pixel of a frame.
- sp_spi_miso  out  1  SPI data out.

## Operation
- Registers (addr: name):
  - 0x00 ID, RO = CHIP_ID.
  - 0x01 CTRL, RW, reset 0: bit0 RUN, bit1 PAT (0 = ramp, 1 = echo), bits 7:2 read 0.
  - 0x02 SEED, RW, reset 0.
  - 0x03 FCNT, RO: frames completed, 8-bit wrap.
  - Other addresses: writes ignored, reads return 0.
- SPI frame, MSB first, one bit per clk while cs low:
  - Bit 0: R/W (1 = read).
  - Bits 1–7: 7-bit address.
  - Bits 8–15 on a write: data captured from mosi. Register is updated on the cycle after bit 15.
  - Bits 8–15 on a read: miso drives the register value, snapshotted when the last address bit is sampled.
  - cs rising before bit 15 aborts the transaction: no write occurs and the bit counter resets.
  - cs held low past bit 15: extra bits are ignored and miso = 0.
  - miso = 0 whenever not driving read data.
- Frame FSM states IDLE, STREAM, GAP:
  - IDLE → STREAM when RUN = 1. PAT is latched at this transition.
  - STREAM: one pixel per cycle, pix_cnt 0..PIXELS-1.
  - STREAM → GAP after pixel PIXELS-1. FCNT increments on that cycle.
  - GAP: GAP cycles. Then → STREAM if RUN = 1, else → IDLE. PAT is re-latched on entry to STREAM.
- Pixel value (8-bit, mod 256):
  - ramp: SEED + FCNT + pix_cnt[7:0].
  - echo: sp_din sampled on the previous cycle.
- Clearing RUN mid-frame does not truncate the frame; the current frame completes and the FSM then goes through GAP to IDLE.
- An SPI write to CTRL during STREAM changes PAT only at the next frame start.

## Timing
- Reset (rst, or sp_nrst low) clears all of the following:
  - outputs: sp_dout = 0, sp_update = 0, sp_eof = 0, sp_spi_miso = 0;
  - FSM → IDLE;
  - registers and counters → 0;
  - SPI shift state → idle.
- Reset mid-frame or mid-SPI takes effect on the next edge, with no partial EOF.
- All outputs are registered.
- Stream latency:
  - sp_update first rises 1 cycle after the IDLE → STREAM decision.
  - During STREAM, updates are back-to-back every cycle: exactly PIXELS consecutive strobes, then GAP low cycles.
  - sp_dout holds its last value when sp_update = 0.
- Echo latency: sp_din at cycle n appears on sp_dout at cycle n+2.
- miso: the read data MSB is valid in the cycle in which mosi bit 8 is sampled, then one bit per cycle.
- SPI and frame logic run concurrently. An FCNT increment and an FCNT read snapshot in the same cycle return the pre-increment value.

## Structure
- Package sp_emu_pkg holds:
  - register address localparams;
  - CTRL bit indices;
  - FSM state enum (IDLE, STREAM, GAP);
  - SPI bit-count width.
- Sub-module sp_emu_spi: SPI responder and register file. It exports CTRL/SEED to the top and imports FCNT from it.
- The frame FSM and pattern generator live in the top level.

## Test plan
- Reset: rst high 3 cycles → all outputs 0; SPI read of 0x00 returns 0x5A; read of 0x01 returns 0x00.
- Ramp stream (PIXELS = 8, GAP = 2): write SEED = 0x10, then CTRL = 0x01.
  - Frame 0: bytes 0x10..0x17, eof with 0x17, then 2 idle cycles.
  - Frame 1: bytes 0x11..0x18.
  - FCNT reads 2 after two frames.
- Echo: set CTRL = 0x03 and drive sp_din = 0xA0, 0xA1, … → sp_dout repeats the sequence 2 cycles later.
- RUN cleared at pixel 3 of 8 → pixels 4..7 still emitted with eof, then IDLE with no further updates.
- SPI abort: cs deasserts after 12 bits of a write to SEED → SEED unchanged; the next complete transaction works.
- sp_nrst low for 1 cycle mid-frame → outputs 0 next cycle, no eof, FCNT = 0, FSM IDLE.
